// File: rtl/id_issue_queue_if.sv
// IF/EX-side handshake and decode bundle of the id_issue_queue.
// The queue takes the slave view; the surrounding pipeline (or a bench) takes the master view.
interface id_issue_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             iFlush;
    logic             iValid;
    logic             oReady;
    logic [XLEN-1:0]  iPc;
    logic [31:0]      iInstr;
    logic [4:0]       oAddrRs1;
    logic [4:0]       oAddrRs2;
    logic [XLEN-1:0]  iRs1;
    logic [XLEN-1:0]  iRs2;
    logic             iExReady;
    logic             iExValid;
    logic             iExIsLoad;
    logic [4:0]       iExRd;
    logic             oExValid;
    logic [XLEN-1:0]  oExPc;
    logic [6:0]       oExOpcode;
    logic [2:0]       oExFunc3;
    logic [6:0]       oExFunc7;
    logic [4:0]       oExRd;
    logic [4:0]       oExRs1Addr;
    logic [4:0]       oExRs2Addr;
    logic [XLEN-1:0]  oExRs1;
    logic [XLEN-1:0]  oExRs2;
    logic [XLEN-1:0]  oExImm;
    logic             oExImmEn;
    logic             oBrTrue;
    logic [XLEN-1:0]  oBrPc;
    logic [CNT_W-1:0] oStallCnt;

    modport slave (
        input  iFlush, iValid, iPc, iInstr, iRs1, iRs2, iExReady, iExValid, iExIsLoad, iExRd,
        output oReady, oAddrRs1, oAddrRs2, oExValid, oExPc, oExOpcode, oExFunc3, oExFunc7,
               oExRd, oExRs1Addr, oExRs2Addr, oExRs1, oExRs2, oExImm, oExImmEn, oBrTrue,
               oBrPc, oStallCnt
    );

    modport master (
        output iFlush, iValid, iPc, iInstr, iRs1, iRs2, iExReady, iExValid, iExIsLoad, iExRd,
        input  oReady, oAddrRs1, oAddrRs2, oExValid, oExPc, oExOpcode, oExFunc3, oExFunc7,
               oExRd, oExRs1Addr, oExRs2Addr, oExRs1, oExRs2, oExImm, oExImmEn, oBrTrue,
               oBrPc, oStallCnt
    );
endinterface

// File: rtl/id_issue_queue.sv
// Decode stage with a DEPTH-entry instruction queue: decodes the head entry, detects
// load-use hazards against EX, resolves branches/JAL early and drives a registered EX bundle.
module id_issue_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 iClk,
    input  logic                 nRst,
    id_issue_queue_if.slave      bus_io
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpAluI   = 7'b0010011;
    localparam logic [6:0] OpAluR   = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic            imm_en;
        logic            br_true;
        logic [XLEN-1:0] br_pc;
    } ex_t;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    ex_t              ex_q, ex_d, dec;

    logic [31:0]      ins;
    logic [XLEN-1:0]  head_pc;
    logic [31:0]      imm32;
    logic             use_rs1, use_rs2, use_rd, imm_en;
    logic             cond, br_taken, not_empty, hazard, deq, redirect, push, push_ok;

    assign ins       = instr_mem[rd_ptr_q];
    assign head_pc   = pc_mem[rd_ptr_q];
    assign not_empty = (count_q != '0);

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        imm_en  = 1'b0;
        imm32   = '0;
        case (ins[6:0])
            OpAluI, OpLoad, OpJalr: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm_en  = 1'b1;
                imm32   = {{20{ins[31]}}, ins[31:20]};
            end
            OpLui, OpAuipc: begin
                use_rd = 1'b1;
                imm_en = 1'b1;
                imm32  = {ins[31:12], 12'b0};
            end
            OpAluR: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OpBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_en  = 1'b1;
                imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OpJal: begin
                use_rd = 1'b1;
                imm_en = 1'b1;
                imm32  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OpStore: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_en  = 1'b1;
                imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ins[14:12])
            3'b000:  cond = (bus_io.iRs1 == bus_io.iRs2);
            3'b001:  cond = (bus_io.iRs1 != bus_io.iRs2);
            3'b100:  cond = ($signed(bus_io.iRs1) < $signed(bus_io.iRs2));
            3'b101:  cond = ($signed(bus_io.iRs1) >= $signed(bus_io.iRs2));
            3'b110:  cond = (bus_io.iRs1 < bus_io.iRs2);
            3'b111:  cond = (bus_io.iRs1 >= bus_io.iRs2);
            default: cond = 1'b0;
        endcase
    end

    assign br_taken = ((ins[6:0] == OpBranch) && cond) || (ins[6:0] == OpJal);

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = head_pc;
        dec.opcode   = ins[6:0];
        dec.func3    = ins[14:12];
        dec.func7    = ins[31:25];
        dec.rd       = use_rd  ? ins[11:7]   : 5'd0;
        dec.rs1_addr = use_rs1 ? ins[19:15]  : 5'd0;
        dec.rs2_addr = use_rs2 ? ins[24:20]  : 5'd0;
        dec.rs1      = use_rs1 ? bus_io.iRs1 : '0;
        dec.rs2      = use_rs2 ? bus_io.iRs2 : '0;
        dec.imm      = XLEN'($signed(imm32));
        dec.imm_en   = imm_en;
        dec.br_true  = br_taken;
        dec.br_pc    = br_taken ? head_pc + XLEN'($signed(imm32)) : '0;
    end

    assign hazard = bus_io.iExValid && bus_io.iExIsLoad && (bus_io.iExRd != 5'd0) &&
                    ((use_rs1 && (ins[19:15] == bus_io.iExRd)) ||
                     (use_rs2 && (ins[24:20] == bus_io.iExRd)));
    assign deq      = not_empty && !hazard && bus_io.iExReady && !bus_io.iFlush;
    assign redirect = deq && br_taken;
    assign push     = bus_io.iValid && bus_io.oReady;
    assign push_ok  = push && !bus_io.iFlush && !redirect;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus_io.iFlush || redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CntW'(push) - CntW'(deq);
        end
    end

    always_comb begin
        ex_d    = ex_q;
        stall_d = stall_q;
        if (bus_io.iFlush) begin
            ex_d.valid   = 1'b0;
            ex_d.br_true = 1'b0;
        end else if (bus_io.iExReady) begin
            if (deq) begin
                ex_d = dec;
            end else begin
                ex_d.valid   = 1'b0;
                ex_d.br_true = 1'b0;
                ex_d.br_pc   = '0;
            end
        end
        if (hazard && not_empty && bus_io.iExReady && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
            ex_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            ex_q     <= ex_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read as valid.
    always_ff @(posedge iClk) begin
        if (nRst && push_ok) begin
            pc_mem[wr_ptr_q]    <= bus_io.iPc;
            instr_mem[wr_ptr_q] <= bus_io.iInstr;
        end
    end

    assign bus_io.oReady     = nRst && (count_q != CntW'(DEPTH));
    assign bus_io.oAddrRs1   = ins[19:15];
    assign bus_io.oAddrRs2   = ins[24:20];
    assign bus_io.oExValid   = ex_q.valid;
    assign bus_io.oExPc      = ex_q.pc;
    assign bus_io.oExOpcode  = ex_q.opcode;
    assign bus_io.oExFunc3   = ex_q.func3;
    assign bus_io.oExFunc7   = ex_q.func7;
    assign bus_io.oExRd      = ex_q.rd;
    assign bus_io.oExRs1Addr = ex_q.rs1_addr;
    assign bus_io.oExRs2Addr = ex_q.rs2_addr;
    assign bus_io.oExRs1     = ex_q.rs1;
    assign bus_io.oExRs2     = ex_q.rs2;
    assign bus_io.oExImm     = ex_q.imm;
    assign bus_io.oExImmEn   = ex_q.imm_en;
    assign bus_io.oBrTrue    = ex_q.br_true;
    assign bus_io.oBrPc      = ex_q.br_pc;
    assign bus_io.oStallCnt  = stall_q;
endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue: a decode vector table plus hand-written sequences for
// queue fill, load-use stalls, branch redirect and flush.
module tb_id_issue_queue;
    logic iClk = 1'b0;
    logic nRst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   exp_stall = 0;

    always #5 iClk = ~iClk;

    id_issue_queue_if #(.XLEN(32), .CNT_W(16)) bus ();

    id_issue_queue #(.XLEN(32), .DEPTH(4), .CNT_W(16)) dut (
        .iClk   (iClk),
        .nRst   (nRst),
        .bus_io (bus)
    );

    typedef struct {
        logic [31:0] pc, instr, rs1v, rs2v;
        logic [6:0]  op;
        logic [4:0]  rd, ra1, ra2;
        logic [31:0] e_rs1, e_rs2, imm;
        logic        immen, br;
        logic [31:0] brpc;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        bus.iPc    = pc;
        bus.iInstr = instr;
        bus.iValid = 1'b1;
        tick();
        bus.iValid = 1'b0;
    endtask

    initial begin
        bus.iFlush = 0; bus.iValid = 0; bus.iPc = '0; bus.iInstr = '0;
        bus.iRs1 = '0; bus.iRs2 = '0; bus.iExReady = 1; bus.iExValid = 0;
        bus.iExIsLoad = 0; bus.iExRd = '0;

        //            pc        instr                               rs1v          rs2v
        //            op     rd  ra1 ra2 e_rs1         e_rs2         imm          ie br brpc
        vecs[0]  = '{32'h10,  enc_i(12'hFFD, 0, 0, 1, 7'h13),       32'h55,       32'h66,
                     7'h13, 1, 0, 0, 32'h55,       32'h0,        32'hFFFFFFFD, 1, 0, 32'h0};
        vecs[1]  = '{32'h14,  enc_r(0, 7, 5, 0, 6, 7'h33),          32'h11,       32'h22,
                     7'h33, 6, 5, 7, 32'h11,       32'h22,       32'h0,        0, 0, 32'h0};
        vecs[2]  = '{32'h18,  32'h123451B7,                         32'h11,       32'h22,
                     7'h37, 3, 0, 0, 32'h0,        32'h0,        32'h12345000, 1, 0, 32'h0};
        vecs[3]  = '{32'h1C,  enc_s(12'hFFC, 5, 2, 2),              32'h100,      32'h77,
                     7'h23, 0, 2, 5, 32'h100,      32'h77,       32'hFFFFFFFC, 1, 0, 32'h0};
        vecs[4]  = '{32'h200, enc_j(21'h1FFFF8, 1),                 32'h9,        32'h9,
                     7'h6F, 1, 0, 0, 32'h0,        32'h0,        32'hFFFFFFF8, 1, 1, 32'h1F8};
        vecs[5]  = '{32'h100, enc_b(13'h020, 2, 1, 0),              32'h7,        32'h7,
                     7'h63, 0, 1, 2, 32'h7,        32'h7,        32'h20,       1, 1, 32'h120};
        vecs[6]  = '{32'h100, enc_b(13'h020, 2, 1, 0),              32'h7,        32'h8,
                     7'h63, 0, 1, 2, 32'h7,        32'h8,        32'h20,       1, 0, 32'h0};
        vecs[7]  = '{32'h300, enc_b(13'h010, 2, 1, 6),              32'hFFFFFFFF, 32'h1,
                     7'h63, 0, 1, 2, 32'hFFFFFFFF, 32'h1,        32'h10,       1, 0, 32'h0};
        vecs[8]  = '{32'h300, enc_b(13'h010, 2, 1, 4),              32'hFFFFFFFF, 32'h1,
                     7'h63, 0, 1, 2, 32'hFFFFFFFF, 32'h1,        32'h10,       1, 1, 32'h310};
        vecs[9]  = '{32'h40,  enc_i(12'h004, 3, 0, 1, 7'h67),       32'h1000,     32'h5,
                     7'h67, 1, 3, 0, 32'h1000,     32'h0,        32'h4,        1, 0, 32'h0};
        vecs[10] = '{32'h44,  32'hFFFFFFFF,                         32'h5,        32'h6,
                     7'h7F, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0};
        vecs[11] = '{32'h90,  32'h80000217,                         32'h5,        32'h6,
                     7'h17, 4, 0, 0, 32'h0,        32'h0,        32'h80000000, 1, 0, 32'h0};

        // Reset held with IF pushing.
        nRst = 0; bus.iValid = 1; bus.iInstr = 32'h00100093;
        repeat (3) tick();
        chk("rst.ready", 32'(bus.oReady), 0);
        chk("rst.valid", 32'(bus.oExValid), 0);
        chk("rst.br", 32'(bus.oBrTrue), 0);
        chk("rst.pc", bus.oExPc, 0);
        chk("rst.stall", 32'(bus.oStallCnt), 0);
        nRst = 1; bus.iValid = 0;
        #1;
        chk("rst.ready_after", 32'(bus.oReady), 1);
        tick();
        chk("rst.no_issue", 32'(bus.oExValid), 0);

        for (int v = 0; v < 12; v++) begin
            logic got;
            bus.iRs1 = vecs[v].rs1v;
            bus.iRs2 = vecs[v].rs2v;
            push(vecs[v].pc, vecs[v].instr);
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                tick();
                got = bus.oExValid;
            end
            chk($sformatf("v%0d.valid", v), 32'(got), 1);
            chk($sformatf("v%0d.pc", v), bus.oExPc, vecs[v].pc);
            chk($sformatf("v%0d.op", v), 32'(bus.oExOpcode), 32'(vecs[v].op));
            chk($sformatf("v%0d.rd", v), 32'(bus.oExRd), 32'(vecs[v].rd));
            chk($sformatf("v%0d.ra1", v), 32'(bus.oExRs1Addr), 32'(vecs[v].ra1));
            chk($sformatf("v%0d.ra2", v), 32'(bus.oExRs2Addr), 32'(vecs[v].ra2));
            chk($sformatf("v%0d.rs1", v), bus.oExRs1, vecs[v].e_rs1);
            chk($sformatf("v%0d.rs2", v), bus.oExRs2, vecs[v].e_rs2);
            chk($sformatf("v%0d.imm", v), bus.oExImm, vecs[v].imm);
            chk($sformatf("v%0d.immen", v), 32'(bus.oExImmEn), 32'(vecs[v].immen));
            chk($sformatf("v%0d.br", v), 32'(bus.oBrTrue), 32'(vecs[v].br));
            chk($sformatf("v%0d.brpc", v), bus.oBrPc, vecs[v].brpc);
        end
        tick();

        // Fill the queue with EX blocked, then drain in order.
        bus.iExReady = 0;
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), enc_i(12'(-(i + 1)), 0, 0,
                                                                     5'(i + 1), 7'h13));
        chk("full.ready", 32'(bus.oReady), 0);
        push(32'h410, enc_i(12'h009, 0, 0, 9, 7'h13));
        chk("full.ready_held", 32'(bus.oReady), 0);
        bus.iExReady = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain%0d.valid", i), 32'(bus.oExValid), 1);
            chk($sformatf("drain%0d.pc", i), bus.oExPc, 32'h400 + 32'(4 * i));
            chk($sformatf("drain%0d.rd", i), 32'(bus.oExRd), 32'(i + 1));
            chk($sformatf("drain%0d.imm", i), bus.oExImm, 32'(-(i + 1)));
        end
        tick();
        chk("drain.empty", 32'(bus.oExValid), 0);

        // Load-use hazard on rs1 of an R-type, then on rs2 of a store.
        bus.iExValid = 1; bus.iExIsLoad = 1; bus.iExRd = 5;
        push(32'h500, enc_r(0, 7, 5, 0, 6, 7'h33));
        chk("haz.addr_rs1", 32'(bus.oAddrRs1), 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_stall++;
            chk($sformatf("haz%0d.valid", i), 32'(bus.oExValid), 0);
            chk($sformatf("haz%0d.stall", i), 32'(bus.oStallCnt), 32'(exp_stall));
        end
        bus.iExRd = 0;
        tick();
        chk("haz.rd0.valid", 32'(bus.oExValid), 1);
        chk("haz.rd0.rd", 32'(bus.oExRd), 6);
        chk("haz.rd0.stall", 32'(bus.oStallCnt), 32'(exp_stall));
        bus.iExRd = 5;
        push(32'h504, enc_s(12'h000, 5, 2, 2));
        tick();
        exp_stall++;
        chk("hazsw.valid", 32'(bus.oExValid), 0);
        chk("hazsw.stall", 32'(bus.oStallCnt), 32'(exp_stall));
        bus.iExValid = 0;
        tick();
        chk("hazsw.issue", 32'(bus.oExValid), 1);
        chk("hazsw.ra2", 32'(bus.oExRs2Addr), 5);
        chk("hazsw.stall_hold", 32'(bus.oStallCnt), 32'(exp_stall));
        bus.iExIsLoad = 0;

        // Taken beq squashes two younger entries and a same-cycle push.
        bus.iExReady = 0; bus.iRs1 = 7; bus.iRs2 = 7;
        push(32'h100, enc_b(13'h020, 2, 1, 0));
        push(32'h104, enc_i(12'h001, 0, 0, 1, 7'h13));
        push(32'h108, enc_i(12'h002, 0, 0, 2, 7'h13));
        bus.iExReady = 1;
        bus.iPc = 32'h700; bus.iInstr = enc_i(12'h003, 0, 0, 3, 7'h13); bus.iValid = 1;
        tick();
        bus.iValid = 0;
        chk("brt.valid", 32'(bus.oExValid), 1);
        chk("brt.br", 32'(bus.oBrTrue), 1);
        chk("brt.brpc", bus.oBrPc, 32'h120);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("brt.squash%0d", i), 32'(bus.oExValid), 0);
            chk($sformatf("brt.br_clr%0d", i), 32'(bus.oBrTrue), 0);
        end

        // Not-taken beq lets the younger entries through.
        bus.iExReady = 0; bus.iRs2 = 8;
        push(32'h100, enc_b(13'h020, 2, 1, 0));
        push(32'h104, enc_i(12'h001, 0, 0, 1, 7'h13));
        push(32'h108, enc_i(12'h002, 0, 0, 2, 7'h13));
        bus.iExReady = 1;
        tick();
        chk("brn.valid", 32'(bus.oExValid), 1);
        chk("brn.br", 32'(bus.oBrTrue), 0);
        tick();
        chk("brn.y0", bus.oExPc, 32'h104);
        chk("brn.y0v", 32'(bus.oExValid), 1);
        tick();
        chk("brn.y1", bus.oExPc, 32'h108);
        chk("brn.y1v", 32'(bus.oExValid), 1);
        tick();

        // Flush with a pending push, a non-empty queue and a held redirect.
        push(32'h600, enc_j(21'h000010, 1));
        tick();
        chk("fl.pre_br", 32'(bus.oBrTrue), 1);
        chk("fl.pre_brpc", bus.oBrPc, 32'h610);
        bus.iExReady = 0;
        push(32'h604, enc_i(12'h001, 0, 0, 1, 7'h13));
        push(32'h608, enc_i(12'h002, 0, 0, 2, 7'h13));
        chk("fl.pre_valid", 32'(bus.oExValid), 1);
        bus.iFlush = 1;
        push(32'h60C, enc_i(12'h003, 0, 0, 3, 7'h13));
        bus.iFlush = 0;
        chk("fl.valid", 32'(bus.oExValid), 0);
        chk("fl.br", 32'(bus.oBrTrue), 0);
        chk("fl.ready", 32'(bus.oReady), 1);
        bus.iExReady = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl.empty%0d", i), 32'(bus.oExValid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
